// File: rtl/signed_divider_16x8.sv
// signed_divider_16x8: iterative restoring divider, 16-bit signed dividend by
// 8-bit signed divisor, giving an 8-bit quotient truncated toward zero, an
// 8-bit remainder carrying the dividend's sign, and saturation/div-by-zero flags.
//
// Optional build macro: SIGNED_DIV_EARLY_OUT_EN
//   When defined, a zero dividend or a divisor of magnitude 1 skips the
//   iterative phase. Results are identical either way; only latency changes.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. Operands are taken only on the in_valid && in_ready edge; the result
// stays valid and stable from out_valid rising until the out_valid && out_ready
// edge. The two handshakes never overlap in the same cycle.
module signed_divider_16x8 #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVISOR_W-1:0]  quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  overflow,
    output logic                  div_zero,
    output logic [1:0]            dbg_state
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);
    localparam int MAG_W = DIVIDEND_W + 1;   // |dividend|, no wrap for the most negative value
    localparam int DVS_W = DIVISOR_W + 1;    // |divisor|, holds 128 for -128
    localparam int PR_W  = DIVISOR_W + 1;    // partial remainder; borrow is one bit above the trial

    localparam logic [DIVISOR_W-1:0]  SAT_POS = {1'b0, {(DIVISOR_W-1){1'b1}}};
    localparam logic [DIVISOR_W-1:0]  SAT_NEG = {1'b1, {(DIVISOR_W-1){1'b0}}};
    localparam logic [DIVIDEND_W-1:0] POS_LIM = {{(DIVIDEND_W-DIVISOR_W){1'b0}}, SAT_POS};
    localparam logic [DIVIDEND_W-1:0] NEG_LIM = {{(DIVIDEND_W-DIVISOR_W){1'b0}}, SAT_NEG};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [MAG_W-1:0]      dvd_mag_q, dvd_mag_d;
    logic [DVS_W-1:0]      dvs_mag_q, dvs_mag_d;
    logic                  dvd_sign_q, dvd_sign_d;
    logic                  dvs_sign_q, dvs_sign_d;
    logic                  zero_q, zero_d;
    logic [PR_W-1:0]       prem_q, prem_d;
    logic [DIVIDEND_W-1:0] qmag_q, qmag_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [DIVISOR_W-1:0]  quotient_q, quotient_d;
    logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
    logic                  overflow_q, overflow_d;
    logic                  div_zero_q, div_zero_d;

    // Operand magnitudes, formed one bit wider than the operands
    logic [MAG_W-1:0] dvd_ext, dvd_abs;
    logic [DVS_W-1:0] dvs_ext, dvs_abs;
    assign dvd_ext = {dividend[DIVIDEND_W-1], dividend};
    assign dvd_abs = dividend[DIVIDEND_W-1] ? -dvd_ext : dvd_ext;
    assign dvs_ext = {divisor[DIVISOR_W-1], divisor};
    assign dvs_abs = divisor[DIVISOR_W-1] ? -dvs_ext : dvs_ext;

    // One restoring step: shift in the next dividend bit, trial-subtract |divisor|
    logic [PR_W:0]   shifted;
    logic [PR_W+1:0] trial;
    logic            borrow;
    logic [PR_W-1:0] step_rem;
    logic            unused_trial_bit;
    assign shifted  = {prem_q, dvd_mag_q[DIVIDEND_W-1]};
    assign trial    = {1'b0, shifted} - {2'b00, dvs_mag_q};
    assign borrow   = trial[PR_W+1];
    assign step_rem = borrow ? shifted[PR_W-1:0] : trial[PR_W-1:0];
    // With no borrow the difference is below |divisor| <= 2^(DIVISOR_W), so this bit is zero
    assign unused_trial_bit = trial[PR_W];

    // Sign application and saturation, evaluated from the finished magnitudes
    logic                 res_neg;
    logic                 ovf;
    logic [DIVISOR_W-1:0] qlow, rlow, dlow;
    assign res_neg = dvd_sign_q ^ dvs_sign_q;
    assign ovf     = res_neg ? (qmag_q > NEG_LIM) : (qmag_q > POS_LIM);
    assign qlow    = qmag_q[DIVISOR_W-1:0];
    assign rlow    = prem_q[DIVISOR_W-1:0];
    assign dlow    = dvd_mag_q[DIVISOR_W-1:0];

    // Next-state and datapath register updates for the IDLE/CALC/FIX/DONE sequence
    always_comb begin
        state_d     = state_q;
        dvd_mag_d   = dvd_mag_q;
        dvs_mag_d   = dvs_mag_q;
        dvd_sign_d  = dvd_sign_q;
        dvs_sign_d  = dvs_sign_q;
        zero_d      = zero_q;
        prem_d      = prem_q;
        qmag_d      = qmag_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        overflow_d  = overflow_q;
        div_zero_d  = div_zero_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvd_mag_d  = dvd_abs;
                    dvs_mag_d  = dvs_abs;
                    dvd_sign_d = dividend[DIVIDEND_W-1];
                    dvs_sign_d = divisor[DIVISOR_W-1];
                    zero_d     = (divisor == '0);
                    prem_d     = '0;
                    qmag_d     = '0;
                    cnt_d      = CNT_W'(DIVIDEND_W);
                    in_ready_d = 1'b0;
                    state_d    = (divisor == '0) ? FIX : CALC;
`ifdef SIGNED_DIV_EARLY_OUT_EN
                    // Trivial quotients: 0 for a zero dividend, |dividend| for |divisor| == 1
                    if ((divisor != '0) && ((dividend == '0) || (dvs_abs == DVS_W'(1)))) begin
                        qmag_d  = dvd_abs[DIVIDEND_W-1:0];
                        state_d = FIX;
                    end
`endif
                end
            end
            CALC: begin
                prem_d    = step_rem;
                qmag_d    = {qmag_q[DIVIDEND_W-2:0], ~borrow};
                dvd_mag_d = dvd_mag_q << 1;
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (zero_q) begin
                    quotient_d  = dvd_sign_q ? SAT_NEG : SAT_POS;
                    remainder_d = dvd_sign_q ? -dlow : dlow;
                    overflow_d  = 1'b0;
                    div_zero_d  = 1'b1;
                end else if (ovf) begin
                    quotient_d  = res_neg ? SAT_NEG : SAT_POS;
                    remainder_d = '0;
                    overflow_d  = 1'b1;
                    div_zero_d  = 1'b0;
                end else begin
                    quotient_d  = res_neg ? -qlow : qlow;
                    remainder_d = dvd_sign_q ? -rlow : rlow;
                    overflow_d  = 1'b0;
                    div_zero_d  = 1'b0;
                end
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All state registers; synchronous reset aborts any division in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dvd_mag_q   <= '0;
            dvs_mag_q   <= '0;
            dvd_sign_q  <= 1'b0;
            dvs_sign_q  <= 1'b0;
            zero_q      <= 1'b0;
            prem_q      <= '0;
            qmag_q      <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            overflow_q  <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_mag_q   <= dvd_mag_d;
            dvs_mag_q   <= dvs_mag_d;
            dvd_sign_q  <= dvd_sign_d;
            dvs_sign_q  <= dvs_sign_d;
            zero_q      <= zero_d;
            prem_q      <= prem_d;
            qmag_q      <= qmag_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            overflow_q  <= overflow_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign overflow  = overflow_q;
    assign div_zero  = div_zero_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_signed_divider_16x8.sv
// Bench for signed_divider_16x8: directed test-plan cases, backpressure,
// mid-operation reset and randomized operands checked against an
// integer-arithmetic reference model.
module tb_signed_divider_16x8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        overflow;
    logic        div_zero;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    signed_divider_16x8 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .overflow  (overflow),
        .div_zero  (div_zero),
        .dbg_state (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division, truncating toward zero
    function automatic void ref_div(input logic [15:0] a, input logic [7:0] b,
                                    output logic [7:0] q, output logic [7:0] r,
                                    output logic ov, output logic dz);
        int ai, bi, qi, ri;
        ai = $signed(a);
        bi = $signed(b);
        ov = 1'b0;
        dz = 1'b0;
        if (bi == 0) begin
            dz = 1'b1;
            q  = (ai < 0) ? 8'h80 : 8'h7f;
            r  = a[7:0];
        end else begin
            qi = ai / bi;
            ri = ai % bi;
            if (qi > 127) begin
                ov = 1'b1; q = 8'h7f; r = 8'h00;
            end else if (qi < -128) begin
                ov = 1'b1; q = 8'h80; r = 8'h00;
            end else begin
                q = qi[7:0];
                r = ri[7:0];
            end
        end
    endfunction

    // Edges from the accept edge (counted as 1) to out_valid visible
    function automatic int exp_lat(input logic [15:0] a, input logic [7:0] b);
        if (b == 8'h00) return 2;
`ifdef SIGNED_DIV_EARLY_OUT_EN
        if (a == 16'h0000 || b == 8'h01 || b == 8'hff) return 2;
`else
        if (a == 16'hffff && b == 8'hff) return 18;
`endif
        return 18;
    endfunction

    // Drive one operation, optionally disturbing inputs while busy, hold the result
    // for 'hold' cycles of backpressure, then release it.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b, input int hold, input bit disturb);
        logic [7:0] eq, er;
        logic       eov, edz;
        int         edges;
        bit         busy_ok, held_ok;
        ref_div(a, b, eq, er, eov, edz);

        edges = 0;
        @(negedge clk);
        while (!in_ready && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        edges    = 1;
        busy_ok  = 1'b1;
        while (!out_valid && edges < 40) begin
            if (in_ready) busy_ok = 1'b0;
            if (disturb) begin
                in_valid = 1'($urandom);
                dividend = 16'($urandom);
                divisor  = 8'($urandom);
            end
            @(posedge clk);
            #1;
            edges++;
        end
        in_valid = 1'b0;
        if (!out_valid) check("timeout", 32'd0, 32'd1);
        check("latency", 32'(edges), 32'(exp_lat(a, b)));
        check("busy_in_ready", 32'({busy_ok, in_ready}), 32'(2'b10));
        check("quotient", 32'(quotient), 32'(eq));
        check("remainder", 32'(remainder), 32'(er));
        check("overflow", 32'(overflow), 32'(eov));
        check("div_zero", 32'(div_zero), 32'(edz));

        held_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (disturb) begin
                in_valid = 1'($urandom);
                dividend = 16'($urandom);
                divisor  = 8'($urandom);
            end
            @(posedge clk);
            #1;
            if (!out_valid || in_ready || quotient !== eq || remainder !== er ||
                overflow !== eov || div_zero !== edz) held_ok = 1'b0;
        end
        in_valid = 1'b0;
        if (hold > 0) check("hold_stable", 32'(held_ok), 32'd1);

        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("release", 32'({out_valid, in_ready, quotient, remainder}), 32'({1'b0, 1'b1, eq, er}));
    endtask

    // Stimulus
    initial begin
        logic [15:0] ra;
        logic [7:0]  rb;
        bit          no_result;

        rst       = 1'b1;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", 32'({in_ready, out_valid, quotient, remainder, overflow, div_zero}),
              32'({1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}));
        rst = 1'b0;

        run_op(16'd1000, 8'd7, 0, 1'b0);
        run_op(-16'sd100, 8'd7, 5, 1'b1);
        run_op(16'h8000, 8'hff, 0, 1'b0);
        run_op(16'd1024, -8'sd8, 0, 1'b0);
        run_op(-16'sd5, 8'h00, 2, 1'b0);
        run_op(16'd0, 8'd5, 0, 1'b0);
        run_op(-16'sd300, 8'h80, 1, 1'b0);
        run_op(16'd127, 8'd1, 0, 1'b0);

        // Reset in the middle of an iterative division
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 16'd30000;
        divisor  = 8'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midreset_outs", 32'({in_ready, out_valid, quotient, remainder, overflow, div_zero}),
              32'({1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}));
        no_result = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid) no_result = 1'b0;
        end
        check("midreset_no_result", 32'(no_result), 32'd1);
        run_op(16'd49, -8'sd7, 0, 1'b0);

        // Randomized operands, biased toward small dividends and corner divisors
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0) ra = 16'($urandom);
            else ra = 16'(int'($urandom_range(0, 4095)) - 2048);
            case ($urandom_range(0, 7))
                0:       rb = 8'h00;
                1:       rb = 8'h01;
                2:       rb = 8'hff;
                3:       rb = 8'h80;
                default: rb = 8'($urandom);
            endcase
            run_op(ra, rb, int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/signed_divider_16x8.md
Name: signed_divider_16x8

Overview:
- Iterative signed divider; the inverse of the signed 8x8 Booth/Wallace multiplier path.
- Takes a 16-bit signed dividend (the multiplier's product range) and an 8-bit signed divisor.
- Returns an 8-bit signed quotient and an 8-bit signed remainder, with saturation and divide-by-zero flags.
- Sits beside the multiplier in the Posit FMAU datapath; uses valid/ready handshakes on both sides.

Parameters:
- DIVIDEND_W, 16, dividend width; also the number of restoring iterations.
- DIVISOR_W, 8, divisor, quotient and remainder width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- dividend  input  DIVIDEND_W  signed two's complement.
- divisor  input  DIVISOR_W  signed two's complement.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- quotient  output  DIVISOR_W  signed, truncated toward zero.
- remainder  output  DIVISOR_W  signed, same sign as dividend, |rem| < |divisor|.
- overflow  output  1  true quotient outside [-128,127]; quotient saturated.
- div_zero  output  1  divisor was 0.

Behaviour:
- Reset: state IDLE; in_ready=1; out_valid=0; quotient=0; remainder=0; overflow=0; div_zero=0; all internal registers cleared.
- Reset mid-operation aborts the current division; no result is produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE: in_ready=1. On in_valid, the accept edge:
  - registers |dividend| (17-bit magnitude), |divisor| (9-bit), both sign bits and the zero-divisor flag;
  - clears the partial remainder and loads the iteration counter with DIVIDEND_W;
  - goes to CALC, or to FIX if divisor==0.
- Inputs are sampled only at the accept edge; later changes are ignored.
- CALC: one restoring step per cycle.
  - Shift the partial remainder left, bringing in the next dividend MSB.
  - Trial-subtract |divisor|. If non-negative, keep the difference and shift a 1 into the quotient magnitude; otherwise restore and shift in a 0.
  - Decrement the counter; go to FIX after DIVIDEND_W steps.
- FIX, one cycle, computes the outputs:
  - Result sign = dividend sign XOR divisor sign. Apply it to the quotient magnitude; apply the dividend sign to the remainder.
  - Overflow when quotient magnitude > 127 with positive sign, or > 128 with negative sign.
  - On overflow: quotient = 0x7F (positive) or 0x80 (negative), remainder = 0, overflow=1.
  - div_zero: quotient = 0x7F if dividend >= 0, else 0x80; remainder = dividend[7:0]; div_zero=1; overflow=0.
  - Go to DONE.
- DONE: out_valid=1, outputs held stable. When out_ready=1, go to IDLE and drop out_valid on the next edge.
  - in_ready rises the cycle after the handshake; there is no same-cycle result-out/operand-in overlap.
- in_ready=0 in CALC, FIX and DONE.
- Latency, normal path: out_valid is visible DIVIDEND_W+2 edges after the accept edge (18 by default).
- Latency, divide-by-zero: out_valid is visible 2 edges after the accept edge.
- Result outputs keep their last values after the DONE handshake until the next FIX.
- Arithmetic:
  - Magnitude of -32768 is formed in 17 bits, so there is no wrap.
  - Divisor -128 has magnitude 128 in 9 bits.
  - The partial remainder is 9 bits plus a borrow bit.

Optional Feature:
- Macro: SIGNED_DIV_EARLY_OUT_EN.
- Defined:
  - dividend==0 with a nonzero divisor skips CALC; the accept edge goes straight to FIX, giving quotient=0, remainder=0 and a 2-edge latency.
  - |divisor|==1 also skips CALC; the quotient magnitude is |dividend|, the remainder is 0 and normal saturation applies.
- Undefined: every nonzero-divisor operation takes the full DIVIDEND_W+2 latency. Results are identical in both builds; only latency differs.

Test Plan:
- dividend=1000, divisor=7: quotient=142 is out of range, so expect overflow=1, quotient=0x7F, remainder=0, out_valid at edge 18.
- dividend=-100, divisor=7: quotient=-14 (0xF2), remainder=-2 (0xFE), overflow=0, div_zero=0.
- dividend=-32768, divisor=-1: overflow=1, quotient=0x7F. dividend=1024, divisor=-8: quotient=0x80, overflow=0, remainder=0.
- divisor=0 with dividend=-5: out_valid at edge 2, div_zero=1, quotient=0x80, remainder=0xFB.
- Backpressure: hold out_ready=0 for 5 cycles in DONE. Outputs stay stable and in_ready=0. Toggling in_valid or the operands during CALC does not change the result.
- Assert rst mid-CALC: next cycle in_ready=1, out_valid=0, all outputs 0. A new operation (dividend=49, divisor=-7) then yields quotient=0xF9, remainder=0.
